// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the adder issue scheduler and its operation-level model.
// Struct widths follow the default configuration (4 requesters, 5-bit dest, 8 flags).
package adder_sched_pkg;

  localparam int DATA_W      = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_FLAG_W  = 8;

  // One extra select bit above the flag index so that all-ones means "always".
  function automatic int cond_sel_w(input int flag_w);
    return $clog2(flag_w) + 1;
  endfunction

  localparam int DEF_COND_SEL_W = cond_sel_w(DEF_FLAG_W);
  localparam int DEF_ID_W       = $clog2(DEF_NUM_REQ);

  localparam logic [DEF_COND_SEL_W-1:0] COND_ALWAYS = '1;

  typedef struct packed {
    logic [DATA_W-1:0]         op1;
    logic [DATA_W-1:0]         op2;
    logic [DEF_ADDR_W-1:0]     dest;
    logic [DEF_COND_SEL_W-1:0] cond;
  } adder_req_t;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
    logic                  carry;
    logic [DEF_ID_W-1:0]   id;
  } adder_wb_t;

endpackage

// File: rtl/adder_sched_rr.sv
// Round-robin arbiter: search starts one past the last winner; pointer moves only on a grant.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

  // Reset to N-1 so requester 0 has first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IW'(N - 1);
    end else if (found) begin
      ptr <= index;
    end
  end

endmodule

// File: rtl/adder_sched.sv
// Issue scheduler for the shared 32-bit adder: round-robin grant, condition check,
// and a two-stage valid/ready pipeline (S1 issue register, S2 write-back register).
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_W     = 5,
  parameter  int FLAG_W     = 8,
  localparam int COND_SEL_W = cond_sel_w(FLAG_W),
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*32-1:0]        req_op1,
  input  logic [NUM_REQ*32-1:0]        req_op2,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_dest,
  input  logic [NUM_REQ*COND_SEL_W-1:0] req_cond,
  input  logic [FLAG_W-1:0]            flags_i,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic                         wb_we,
  output logic [ADDR_W-1:0]            wb_dest,
  output logic [31:0]                  wb_data,
  output logic                         wb_carry,
  output logic [ID_W-1:0]              wb_id,
  output logic [15:0]                  stat_issued,
  output logic [15:0]                  stat_skipped
);

  localparam logic [COND_SEL_W-1:0] COND_ALL = '1;
  localparam logic [COND_SEL_W-1:0] FLAG_LIM = COND_SEL_W'(FLAG_W);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is combinational from req_valid; wb_* hold while wb_valid & !wb_ready.
  logic s1_valid, s2_load, s1_adv, s1_load;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx;
  logic [31:0]            s1_op1, s1_op2;
  logic [ADDR_W-1:0]      s1_dest;
  logic [ID_W-1:0]        s1_id;
  logic                   s1_ok;
  logic [31:0]            sel_op1, sel_op2;
  logic [ADDR_W-1:0]      sel_dest;
  logic [COND_SEL_W-1:0]  sel_cond;
  logic                   sel_ok;
  logic [32:0]            sum;

  assign s2_load   = !wb_valid || wb_ready;
  assign s1_adv    = s1_valid && s2_load;
  assign s1_load   = !s1_valid || s1_adv;
  assign req_ready = grant;
  assign sum       = {1'b0, s1_op1} + {1'b0, s1_op2};

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (s1_load),
    .grant (grant),
    .index (gidx)
  );

  always_comb begin
    sel_op1  = '0;
    sel_op2  = '0;
    sel_dest = '0;
    sel_cond = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op1  = req_op1[i*32 +: 32];
        sel_op2  = req_op2[i*32 +: 32];
        sel_dest = req_dest[i*ADDR_W +: ADDR_W];
        sel_cond = req_cond[i*COND_SEL_W +: COND_SEL_W];
      end
    end
    // Selects between FLAG_W and all-ones name no flag and evaluate false.
    sel_ok = 1'b0;
    if (sel_cond == COND_ALL) begin
      sel_ok = 1'b1;
    end else if (sel_cond < FLAG_LIM) begin
      sel_ok = flags_i[sel_cond[COND_SEL_W-2:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_op1       <= '0;
      s1_op2       <= '0;
      s1_dest      <= '0;
      s1_id        <= '0;
      s1_ok        <= 1'b0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_dest      <= '0;
      wb_data      <= '0;
      wb_carry     <= 1'b0;
      wb_id        <= '0;
      stat_issued  <= '0;
      stat_skipped <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= |grant;
        if (|grant) begin
          s1_op1  <= sel_op1;
          s1_op2  <= sel_op2;
          s1_dest <= sel_dest;
          s1_id   <= gidx;
          s1_ok   <= sel_ok;
        end
      end
      // False-condition ops still flow through so completion order matches grant order.
      if (s2_load) begin
        wb_valid <= s1_valid;
        if (s1_valid) begin
          wb_we    <= s1_ok;
          wb_dest  <= s1_dest;
          wb_data  <= s1_ok ? sum[31:0] : 32'd0;
          wb_carry <= s1_ok & sum[32];
          wb_id    <= s1_id;
        end
      end
      if (|grant) begin
        stat_issued <= stat_issued + 16'd1;
        if (!sel_ok) begin
          stat_skipped <= stat_skipped + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched: drivers push expected write-back records into a queue,
// a monitor pops and compares each record the DUT hands over.
module tb_adder_sched;
  import adder_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int FLAG_W  = 8;
  localparam int CSW     = 4;
  localparam int WB_W    = $bits(adder_wb_t);

  logic                       clk;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*32-1:0]      req_op1, req_op2;
  logic [NUM_REQ*ADDR_W-1:0]  req_dest;
  logic [NUM_REQ*CSW-1:0]     req_cond;
  logic [FLAG_W-1:0]          flags_i;
  logic                       wb_valid, wb_ready, wb_we, wb_carry;
  logic [ADDR_W-1:0]          wb_dest;
  logic [31:0]                wb_data;
  logic [1:0]                 wb_id;
  logic [15:0]                stat_issued, stat_skipped;

  logic [WB_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_issued = 0;
  int exp_skipped = 0;

  adder_sched #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_dest(req_dest), .req_cond(req_cond),
    .flags_i(flags_i),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_dest(wb_dest),
    .wb_data(wb_data), .wb_carry(wb_carry), .wb_id(wb_id),
    .stat_issued(stat_issued), .stat_skipped(stat_skipped)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [WB_W-1:0] mk_wb(input logic we, input logic [4:0] dest,
                                             input logic [31:0] data, input logic carry,
                                             input logic [1:0] id);
    adder_wb_t r;
    r.we = we; r.dest = dest; r.data = data; r.carry = carry; r.id = id;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic we, input logic [4:0] dest, input logic [31:0] data,
                          input logic carry, input logic [1:0] id);
    exp_q.push_back(mk_wb(we, dest, data, carry, id));
    exp_issued++;
    if (!we) exp_skipped++;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [WB_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got record id=%0d data=0x%0h, expected none", wb_id, wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_record", 64'({wb_we, wb_dest, wb_data, wb_carry, wb_id}), 64'(e));
        end
      end
    end
  end

  // Driver tasks
  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [3:0] c);
    req_op1[idx*32 +: 32]        = a;
    req_op2[idx*32 +: 32]        = b;
    req_dest[idx*ADDR_W +: ADDR_W] = d;
    req_cond[idx*CSW +: CSW]     = c;
  endtask

  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [3:0] c,
                       input logic we, input logic [31:0] data, input logic carry);
    bit got = 0;
    set_req(idx, a, b, d, c);
    req_valid[idx] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1;
    end
    if (got) begin
      push_exp(we, d, data, carry, 2'(idx));
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: req%0d got no grant, expected grant within 20 cycles", idx);
    end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    bit empty = 0;
    for (int k = 0; k < 50 && !empty; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) empty = 1;
    end
    if (!empty) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d records pending, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic set_all_rr();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(10 * (i + 1)), 32'(i + 1), 5'(i + 1), 4'hF);
  endtask

  // Stimulus
  initial begin
    int rr_order[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    logic [31:0] rr_sum[4] = '{32'd11, 32'd22, 32'd33, 32'd44};
    int acc;

    rst_n = 1'b0; wb_ready = 1'b1; req_valid = '0; flags_i = '0;
    req_op1 = '0; req_op2 = '0; req_dest = '0; req_cond = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_fields", 64'({wb_we, wb_dest, wb_data, wb_carry, wb_id}), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_stat_issued", 64'(stat_issued), 64'd0);
    check("rst_stat_skipped", 64'(stat_skipped), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic add and two-cycle latency
    issue(0, 32'd5, 32'd7, 5'd3, 4'hF, 1'b1, 32'd12, 1'b0);
    @(negedge clk);
    check("latency_t1_not_yet", 64'(wb_valid), 64'd0);
    @(negedge clk);
    check("latency_t2_valid", 64'(wb_valid), 64'd1);
    drain();

    // Carry out
    issue(0, 32'hFFFF_FFFF, 32'd2, 5'd7, 4'hF, 1'b1, 32'd1, 1'b1);
    drain();

    // All requesters valid: round-robin from one past requester 0
    set_all_rr();
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(4'b0001 << rr_order[k]));
      if (k >= 2) check("rr_throughput", 64'(wb_valid), 64'd1);
      push_exp(1'b1, 5'(rr_order[k] + 1), rr_sum[rr_order[k]], 1'b0, 2'(rr_order[k]));
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // Condition evaluation
    flags_i = 8'h00;
    issue(2, 32'd5, 32'd6, 5'd9, 4'd2, 1'b0, 32'd0, 1'b0);
    flags_i = 8'h04;
    issue(2, 32'd5, 32'd6, 5'd9, 4'd2, 1'b1, 32'd11, 1'b0);
    flags_i = 8'hFF;
    issue(1, 32'd1, 32'd1, 5'd4, 4'd9, 1'b0, 32'd0, 1'b0);
    flags_i = 8'h80;
    issue(3, 32'h8000_0000, 32'h8000_0000, 5'd31, 4'd7, 1'b1, 32'd0, 1'b1);
    drain();
    check("stat_issued", 64'(stat_issued), 64'(exp_issued));
    check("stat_skipped", 64'(stat_skipped), 64'(exp_skipped));

    // Backpressure: only two ops fit while write-back is stalled
    wb_ready = 1'b0;
    acc = 0;
    set_req(1, 32'd100, 32'd23, 5'd5, 4'hF);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        push_exp(1'b1, 5'd5, 32'(123 + acc), 1'b0, 2'd1);
        acc++;
      end
      if (k >= 2) begin
        check("stall_ready", 64'(req_ready), 64'd0);
        check("stall_hold", 64'({wb_valid, wb_we, wb_dest, wb_data, wb_carry, wb_id}),
              64'({1'b1, mk_wb(1'b1, 5'd5, 32'd123, 1'b0, 2'd1)}));
      end
      @(posedge clk); #1;
      req_op1[1*32 +: 32] = 32'(100 + acc);
    end
    check("stall_accepts", 64'(acc), 64'd2);
    req_valid = '0;
    wb_ready = 1'b1;
    drain();
    check("stat_issued_bp", 64'(stat_issued), 64'(exp_issued));

    // Reset with both stages full
    wb_ready = 1'b0;
    set_req(0, 32'd1, 32'd1, 5'd1, 4'hF);
    req_valid[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (req_ready[0]) push_exp(1'b1, 5'd1, 32'd2, 1'b0, 2'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    req_valid = '0;
    exp_q.delete();
    exp_issued = 0;
    exp_skipped = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_wb_valid", 64'(wb_valid), 64'd0);
    check("midrst_stat_issued", 64'(stat_issued), 64'd0);
    check("midrst_stat_skipped", 64'(stat_skipped), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_ready = 1'b1;
    set_all_rr();
    req_valid = '1;
    @(negedge clk);
    check("post_rst_grant", 64'(req_ready), 64'd1);
    if (req_ready[0]) push_exp(1'b1, 5'd1, 32'd11, 1'b0, 2'd0);
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_sched.md
# adder_sched

Issue scheduler for the shared 32-bit adder execution unit. Up to NUM_REQ requesters (instruction lanes) present add operations; the block grants one per cycle round-robin and evaluates the operation's single-flag condition against the live flag vector. It computes operand1+operand2 in a two-stage valid/ready pipeline and hands a write-back record (destination, data, write-enable) to the register-file write port.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 5, register destination address width
- FLAG_W, 8, number of condition flags; cond select width is COND_SEL_W = $clog2(FLAG_W)+1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
- req_op1  in  NUM_REQ x 32  operand 1 per requester
- req_op2  in  NUM_REQ x 32  operand 2 per requester
- req_dest  in  NUM_REQ x ADDR_W  destination register
- req_cond  in  NUM_REQ x COND_SEL_W  condition flag select; COND_ALWAYS = all ones
- flags_i  in  FLAG_W  current condition flag vector
- wb_valid  out  1  write-back record valid
- wb_ready  in  1  write-back consumer accepts
- wb_we  out  1  1 = write wb_data to wb_dest; 0 = condition false, no write
- wb_dest  out  ADDR_W  destination register
- wb_data  out  32  sum modulo 2^32 (0 when wb_we=0)
- wb_carry  out  1  bit 32 of the sum (0 when wb_we=0)
- wb_id  out  $clog2(NUM_REQ)  requester index of this record
- stat_issued  out  16  count of accepted operations, wraps
- stat_skipped  out  16  count of accepted operations with false condition, wraps

## Operation
- Stage S1 (issue register): holds granted op1, op2, dest, id, cond_ok.
- Stage S2 (result register): holds wb_* record.
- s2_load = !s2_valid | wb_ready; s1_adv = s1_valid & s2_load; s1_load = !s1_valid | s1_adv.
- Arbiter grants only when s1_load. Priority starts at rr_ptr+1 modulo NUM_REQ; rr_ptr updates to the granted index on a grant.
- req_ready[i] = s1_load & grant[i]. It depends combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- cond_ok is sampled from flags_i in the grant cycle:
  - 1 if req_cond == COND_ALWAYS;
  - else flags_i[req_cond] if req_cond < FLAG_W;
  - else 0.
- Sum is computed 33-bit in the S1→S2 transfer. wb_data = sum[31:0] and wb_carry = sum[32] if cond_ok, else both 0; wb_we = cond_ok.
- False-condition ops still traverse the pipeline, which keeps completion order equal to grant order.
- stat_issued +1 per grant; stat_skipped +1 per grant with cond_ok=0; same-cycle increments both apply.

## Timing
- Reset values: wb_valid=0, wb_we=0, wb_dest=0, wb_data=0, wb_carry=0, wb_id=0, req_ready=0, s1_valid=0, rr_ptr=NUM_REQ-1 (requester 0 wins first), stats=0.
- Reset mid-operation discards in-flight S1/S2 contents; no write-back is emitted for them.
- Latency: a grant at cycle T produces wb_valid at T+2 with no backpressure. Throughput is 1 op/cycle.
- wb_* are held stable while wb_valid & !wb_ready.
- Full pipeline: S1 and S2 valid with wb_ready=0 gives req_ready all 0 that cycle.
- Simultaneous drain and grant: wb_ready=1 with both stages full lets S2 take S1 and S1 take a new grant in the same cycle.
- Single requester continuously valid is granted every cycle (no forced bubble).

## Structure
- Package adder_sched_pkg:
  - COND_ALWAYS, COND_SEL_W helper
  - struct adder_req_t {op1, op2, dest, cond}
  - struct adder_wb_t {we, dest, data, carry, id}
  - shared with the operation-level adder model.
- Sub-module rr_arbiter (parameter N; inputs req, en; outputs one-hot grant, index; internal pointer, reset to N-1).
- adder_sched instantiates rr_arbiter plus the S1/S2 registers and stat counters.

## Test plan
- Reset then req0 valid, op1=5, op2=7, dest=3, cond=ALWAYS, wb_ready=1 -> wb_valid at T+2, we=1, dest=3, data=12, carry=0, id=0.
- op1=0xFFFFFFFF, op2=2 -> data=0x00000001, carry=1.
- All 4 requesters valid continuously, wb_ready=1 -> grant order 0,1,2,3,0,...; one wb per cycle; wb_id matches.
- req_cond=2 with flags_i[2]=0 -> we=0, data=0, stat_skipped=1, stat_issued=1; then flags_i[2]=1 -> we=1.
- wb_ready=0 for 5 cycles with req1 always valid -> exactly 2 accepted, then req_ready=0; wb_* stable; release -> both emitted in order, no loss or duplicate.
- Assert rst_n=0 with both stages full -> next cycle wb_valid=0, stats=0, first post-reset grant goes to requester 0.
